adder_multicycle: RTL and testbench
===================================

Name: adder_multicycle

Overview:
- Parametrised, multi-cycle successor to the CPU's single-cycle combinational adder.
- Adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per clock, carrying between slices in a register.
- Provides carry-in, borrow-aware subtract, status flags, and valid/ready handshakes on both sides.
- Sits in the CPU datapath as an area-reduced ALU add/sub unit, or as a reusable building block for wide arithmetic.

Parameters:
WIDTH, 32, operand and result width in bits.
CHUNK, 8, bits processed per cycle; must divide WIDTH exactly. NCHUNK = WIDTH/CHUNK.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  operands/mode are valid this cycle.
in_ready  output  1  block can accept a new operation.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
sub  input  1  0 = add, 1 = subtract.
carry_in  input  1  carry-in for add; borrow-in for subtract.
out_valid  output  1  result fields are valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result.
carry_out  output  1  carry out of the MSB; for sub, 1 means no borrow.
overflow  output  1  signed two's-complement overflow.
zero  output  1  sum == 0.

Behaviour:
- Interface: single clock; reset is asynchronous and active-low, named `reset`.
- Reset values (while reset is low, immediately, without waiting for a clock edge): state = IDLE, in_ready = 1, out_valid = 0, sum = 0, carry_out = 0, overflow = 0, zero = 0, chunk index = 0, carry register = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1, the block latches a, b_eff = sub ? ~b : b, and carry register = sub ? ~carry_in : carry_in.
  - It also clears chunk index k to 0 and moves to RUN.
- RUN:
  - in_ready = 0.
  - Each edge computes {c, s} = a[k] + b_eff[k] + carry over slice k (CHUNK bits), writes s into sum[k], stores c in the carry register, and increments k.
  - When k == NCHUNK-1 it then also:
    - latches carry_out = c;
    - computes overflow = (a[MSB] == b_eff[MSB]) && (new sum[MSB] != a[MSB]);
    - computes zero = (full new sum == 0);
    - moves to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - sum and flags are held stable while out_ready = 0.
  - On an edge with out_ready = 1 the block goes to IDLE and out_valid drops.
  - Outputs keep their last values in IDLE; they are valid only while out_valid = 1.
- Latency: acceptance on edge T0, slices computed on edges T1..TNCHUNK. out_valid is high in the cycle after edge TNCHUNK, i.e. NCHUNK cycles after acceptance.
- Throughput: one operation per NCHUNK+2 cycles minimum. There is no input/output overlap; a new operation cannot be accepted in the cycle the result is consumed.
- Arithmetic semantics:
  - sub = 0: sum = a + b + carry_in.
  - sub = 1: sum = a - b - carry_in.
  - sum is the result modulo 2^WIDTH; operands are unsigned or two's complement.
- Wrap-around: the chunk index counts 0..NCHUNK-1 only and never wraps within an operation.
- Degenerate case: CHUNK == WIDTH is legal, giving NCHUNK = 1 and latency 1.
- Inputs a, b, sub and carry_in are ignored outside the IDLE accept edge; changes during RUN or DONE have no effect.
- Reset mid-operation (reset low in RUN or DONE): aborts immediately to the reset values; the partial result is discarded and no out_valid is produced.
- in_valid in RUN or DONE: ignored, because in_ready = 0. The producer must hold its request.

Test Plan (WIDTH=32, CHUNK=8, NCHUNK=4):
1. a=0x00000000, b=0x00000000, add, carry_in=0 -> out_valid exactly 4 cycles after accept; sum=0x00000000, zero=1, carry_out=0, overflow=0; in_ready=0 throughout RUN/DONE.
2. a=0x000000FF, b=0x00000001, add -> sum=0x00000100 (carry crosses slice boundary), carry_out=0, zero=0. Then a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, carry_out=1, zero=1, overflow=0.
3. a=0x7FFFFFFF, b=0x00000001, add -> sum=0x80000000, overflow=1, carry_out=0. Then a=0x00000001, b=0x00000001, carry_in=1 -> sum=0x00000003.
4. a=5, b=7, sub=1, carry_in=0 -> sum=0xFFFFFFFE, carry_out=0 (borrow). Then a=7, b=5, sub=1, carry_in=1 -> sum=0x00000001, carry_out=1. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, overflow=1.
5. Hold out_ready=0 for 3 cycles in DONE while toggling a/b/in_valid -> sum/flags unchanged, out_valid stays 1, in_ready stays 0. After out_ready=1: out_valid=0 and in_ready=1 on the next cycle.
6. Assert reset low during RUN after 2 slices -> out_valid=0, in_ready=1, sum=0 without a clock edge. A subsequent 0xFF+1 returns 0x00000100 with normal 4-cycle latency.

Source files
------------

// File: rtl/adder_multicycle_if.sv
// Handshake and data bundle for the multi-cycle adder: the operation request
// travels producer -> adder, and the result travels adder -> consumer.
`timescale 1ns/1ps
interface adder_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport slave (
        input  in_valid, a, b, sub, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero
    );

    modport master (
        output in_valid, a, b, sub, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero
    );
endinterface

// File: rtl/adder_multicycle.sv
// Area-reduced add/sub unit: one CHUNK-bit slice per clock with a registered
// carry between slices, valid/ready on both sides, no input/output overlap.
`timescale 1ns/1ps
module adder_multicycle #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                clock,
    input  logic                reset,
    adder_multicycle_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b_eff;
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_zero;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [CHUNK-1:0] w_a_sl [NCHUNK];
    logic [CHUNK-1:0] w_b_sl [NCHUNK];
    logic [CHUNK:0]   w_slice;
    logic [WIDTH-1:0] w_sum_new;

    // Slice views of the operands, and the full sum with slice k replaced by
    // this cycle's partial result (used for the MSB-based flags on the last slice).
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign w_a_sl[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_b_sl[gi] = r_b_eff[gi*CHUNK +: CHUNK];
            assign w_sum_new[gi*CHUNK +: CHUNK] =
                (r_k == KW'(gi)) ? w_slice[CHUNK-1:0] : r_sum[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_slice = {1'b0, w_a_sl[r_k]} + {1'b0, w_b_sl[r_k]} + {{CHUNK{1'b0}}, r_carry};
    assign w_last  = (r_k == KW'(NCHUNK - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + ~borrow_in, so sub ^ carry_in seeds the carry chain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a         <= '0;
            r_b_eff     <= '0;
            r_carry     <= 1'b0;
            r_k         <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b_eff <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ^ bus.carry_in;
            r_k     <= '0;
        end else if (w_step) begin
            r_sum   <= w_sum_new;
            r_carry <= w_slice[CHUNK];
            if (w_last) begin
                r_carry_out <= w_slice[CHUNK];
                r_overflow  <= (r_a[WIDTH-1] == r_b_eff[WIDTH-1]) &&
                               (w_sum_new[WIDTH-1] != r_a[WIDTH-1]);
                r_zero      <= (w_sum_new == '0);
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_adder_multicycle.sv
// Directed bench for adder_multicycle (WIDTH=32, CHUNK=8): arithmetic vectors,
// latency, output hold under back-pressure, back-to-back ops and async reset.
`timescale 1ns/1ps
module tb_adder_multicycle;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adder_multicycle_if #(.WIDTH(32)) bus ();

    adder_multicycle #(.WIDTH(32), .CHUNK(8)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        ci;
        logic [31:0] sum;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    // Issue one operation from IDLE and wait (bounded) for out_valid; leaves DONE.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic ci, output int lat, output bit rdy_seen);
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        bus.carry_in = ci;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat      = 0;
        rdy_seen = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.carry_in  = 1'b0;
        #3;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 32'h0 ||
            bus.carry_out !== 1'b0 || bus.overflow !== 1'b0 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b sum=%h co=%b ov=%b z=%b, required 1 0 00000000 0 0 0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.carry_out, bus.overflow, bus.zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        vec_t v [10];
        int   lat;
        bit   rdy;
        v[0] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        v[1] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        v[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        v[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        v[4] = '{32'h00000001, 32'h00000001, 1'b0, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0};
        v[5] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        v[6] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0};
        v[7] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        v[8] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
        v[9] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            do_op(v[i].a, v[i].b, v[i].s, v[i].ci, lat, rdy);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d cycles, required 4", i, lat);
            end
            checks++;
            if (rdy !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_busy[%0d]: in_ready seen high during RUN/DONE, required low", i);
            end
            checks++;
            if (bus.sum !== v[i].sum) begin
                errors++;
                $display("FAIL sum[%0d]: got %h, required %h", i, bus.sum, v[i].sum);
            end
            checks++;
            if ({bus.carry_out, bus.overflow, bus.zero} !== {v[i].co, v[i].ov, v[i].z}) begin
                errors++;
                $display("FAIL flags[%0d]: co/ov/z got %b%b%b, required %b%b%b", i,
                         bus.carry_out, bus.overflow, bus.zero, v[i].co, v[i].ov, v[i].z);
            end
            $display("op %0d: a=%h b=%h sub=%b cin=%b -> sum=%h co=%b ov=%b z=%b lat=%0d",
                     i, v[i].a, v[i].b, v[i].s, v[i].ci, bus.sum, bus.carry_out,
                     bus.overflow, bus.zero, lat);
            consume();
        end
    endtask

    task automatic test_hold();
        int lat;
        bit rdy;
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat, rdy);
        for (int c = 0; c < 3; c++) begin
            bus.a        = ~bus.a;
            bus.b        = bus.b + 32'h11;
            bus.in_valid = ~bus.in_valid;
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== 32'h80000000 ||
                bus.carry_out !== 1'b0 || bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: ov=%b ir=%b sum=%h co=%b ov=%b z=%b, required 1 0 80000000 0 1 0",
                         c, bus.out_valid, bus.in_ready, bus.sum, bus.carry_out, bus.overflow, bus.zero);
            end
        end
        bus.in_valid = 1'b0;
        consume();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        $display("hold: result held 3 cycles under back-pressure, then released");
    endtask

    task automatic test_back_to_back();
        int lat;
        bit rdy;
        do_op(32'h00000010, 32'h00000020, 1'b0, 1'b0, lat, rdy);
        consume();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b right after consume, required 1", bus.in_ready);
        end
        do_op(32'hFFFFFF00, 32'h00000100, 1'b1, 1'b0, lat, rdy);
        checks++;
        if (lat !== 4 || bus.sum !== 32'hFFFFFE00 || bus.carry_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_op: lat=%0d sum=%h co=%b, required 4 fffffe00 1", lat, bus.sum, bus.carry_out);
        end
        $display("b2b: second op sum=%h lat=%0d", bus.sum, lat);
        consume();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit rdy;
        bus.a        = 32'hFFFFFFFF;
        bus.b        = 32'h00000001;
        bus.sub      = 1'b0;
        bus.carry_in = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== 32'h0 ||
            bus.carry_out !== 1'b0 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: out_valid=%b in_ready=%b sum=%h co=%b z=%b, required 0 1 00000000 0 0",
                     bus.out_valid, bus.in_ready, bus.sum, bus.carry_out, bus.zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lat, rdy);
        checks++;
        if (lat !== 4 || bus.sum !== 32'h00000100 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_op: lat=%0d sum=%h z=%b, required 4 00000100 0", lat, bus.sum, bus.zero);
        end
        $display("reset mid-run: aborted, follow-up sum=%h lat=%0d", bus.sum, lat);
        consume();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vectors();
        test_hold();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
